// File: rtl/prog_fetch_ctrl.sv
// Instruction sequencer: owns the program counter, latches ROM words through a
// FETCH/EXEC handshake, resolves jumps/halt and counts retired instructions.
module prog_fetch_ctrl #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [15:0]      instr_i,
   input  logic             stall_i,
   input  logic             pc_load_i,
   input  logic [7:0]       pc_target_i,
   input  logic [7:0]       r15_i,
   input  logic             flag_eq_i,
   input  logic             flag_e_i,
   input  logic             flag_f_i,
   output logic [7:0]       pc_o,
   output logic [15:0]      ir_o,
   output logic             exec_o,
   output logic             halt_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] icount_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_EXEC  = 2'b10,
      S_HALT  = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_pc;
   logic [15:0]      r_ir;
   logic [CNT_W-1:0] r_icount;
   logic             w_retire;
   logic             w_cond;
   logic             w_jump;
   logic             w_halt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign w_retire = (r_state == S_EXEC) && !stall_i;
   // ir[1] deliberately takes no part in the jump condition
   assign w_cond   = (r_ir[3] & flag_e_i) | (r_ir[2] & flag_f_i) | (r_ir[0] & flag_eq_i);
   assign w_jump   = (r_ir[15:12] == 4'hE) && w_cond;
   // A simultaneous R15 write outranks the halt opcode
   assign w_halt   = !pc_load_i && (r_ir[15:12] == 4'hF) && (r_ir[3:0] == 4'h0);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (run) w_state_nxt = S_FETCH;
         S_FETCH: w_state_nxt = S_EXEC;
         S_EXEC: begin
            if (!stall_i) begin
               if (w_halt)   w_state_nxt = S_HALT;
               else if (run) w_state_nxt = S_FETCH;
               else          w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_HALT;
      endcase
   end

   always_comb begin
      exec_o  = (r_state == S_EXEC);
      halt_o  = (r_state == S_HALT);
      state_o = r_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_ir     <= 16'h0000;
         r_icount <= '0;
      end else begin
         if (r_state == S_FETCH) r_ir <= instr_i;
         if (w_retire) begin
            r_icount <= sat_inc(r_icount);
            if (pc_load_i)   r_pc <= pc_target_i;
            else if (w_jump) r_pc <= r15_i;
            else if (!w_halt) r_pc <= r_pc + 8'd1;
         end
      end
   end

   assign pc_o     = r_pc;
   assign ir_o     = r_ir;
   assign icount_o = r_icount;

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// Bench for prog_fetch_ctrl: directed scenarios and random traffic compared
// cycle by cycle against an instruction-level reference model.
module tb_prog_fetch_ctrl;

   localparam int TB_CNT_W = 10;
   localparam int CMAX     = (1 << TB_CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst, run, stall, pc_load, feq, fe, ff;
   logic [7:0]          tgt, r15;
   logic [15:0]         instr;
   logic [7:0]          pc;
   logic [15:0]         ir;
   logic                exec_w, halt_w;
   logic [1:0]          state;
   logic [TB_CNT_W-1:0] icount;

   logic [15:0] rom [256];
   int errors = 0;
   int checks = 0;

   // reference model state: 0 idle, 1 fetch, 2 exec, 3 halt
   int          m_st;
   logic [7:0]  m_pc;
   logic [15:0] m_ir;
   int          m_cnt;

   assign instr = rom[pc];

   prog_fetch_ctrl #(.RESET_PC(8'h00), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst(rst), .run(run), .instr_i(instr), .stall_i(stall),
      .pc_load_i(pc_load), .pc_target_i(tgt), .r15_i(r15),
      .flag_eq_i(feq), .flag_e_i(fe), .flag_f_i(ff),
      .pc_o(pc), .ir_o(ir), .exec_o(exec_w), .halt_o(halt_w),
      .state_o(state), .icount_o(icount)
   );

   always #5 clk = ~clk;

   task automatic fill_plain();
      for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
   endtask

   task automatic tick();
      int          n_st  = m_st;
      logic [7:0]  n_pc  = m_pc;
      logic [15:0] n_ir  = m_ir;
      int          n_cnt = m_cnt;
      bit          taken;
      if (rst) begin
         n_st = 0; n_pc = 8'h00; n_ir = 16'h0000; n_cnt = 0;
      end else if (m_st == 0) begin
         if (run) n_st = 1;
      end else if (m_st == 1) begin
         n_ir = rom[m_pc]; n_st = 2;
      end else if (m_st == 2 && !stall) begin
         n_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
         taken = (m_ir[15:12] == 4'hE) && ((m_ir[3] && fe) || (m_ir[2] && ff) || (m_ir[0] && feq));
         n_st  = run ? 1 : 0;
         if (pc_load)                                        n_pc = tgt;
         else if (taken)                                     n_pc = r15;
         else if (m_ir[15:12] == 4'hF && m_ir[3:0] == 4'h0)  n_st = 3;
         else                                                n_pc = 8'((int'(m_pc) + 1) % 256);
      end
      @(posedge clk); #1;
      m_st = n_st; m_pc = n_pc; m_ir = n_ir; m_cnt = n_cnt;
      checks += 6;
      if (pc !== m_pc) begin errors++; $display("FAIL pc: got %h want %h at %0t", pc, m_pc, $time); end
      if (ir !== m_ir) begin errors++; $display("FAIL ir: got %h want %h at %0t", ir, m_ir, $time); end
      if (int'(state) !== m_st) begin errors++; $display("FAIL state: got %0d want %0d at %0t", state, m_st, $time); end
      if (int'(icount) !== m_cnt) begin errors++; $display("FAIL icount: got %0d want %0d at %0t", icount, m_cnt, $time); end
      if (exec_w !== (m_st == 2)) begin errors++; $display("FAIL exec: got %b want %b at %0t", exec_w, (m_st == 2), $time); end
      if (halt_w !== (m_st == 3)) begin errors++; $display("FAIL halt: got %b want %b at %0t", halt_w, (m_st == 3), $time); end
   endtask

   task automatic run_to(input logic [7:0] a);
      int n = 0;
      while (!(m_st == 2 && m_pc == a) && n < 2000) begin tick(); n++; end
      checks++;
      if (n >= 2000) begin errors++; $display("FAIL run_to: pc %h never reached EXEC, want %h", pc, a); end
   endtask

   task automatic goto(input logic [7:0] a);
      int n = 0;
      while (m_st != 2 && n < 100) begin tick(); n++; end
      pc_load = 1'b1; tgt = a; tick(); pc_load = 1'b0;
      run_to(a);
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b1; tick(); tick();
      checks += 4;
      if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
      if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
      if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", ir); end
      if (icount !== '0 || exec_w !== 1'b0 || halt_w !== 1'b0) begin
         errors++; $display("FAIL reset_outs: icount %0d exec %b halt %b want 0 0 0", icount, exec_w, halt_w);
      end
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) rom[i] = 16'h8000 | 16'(i);
      run = 1'b1;
      repeat (9) tick();
      checks++;
      if (icount !== TB_CNT_W'(4) || pc !== 8'h04) begin
         errors++; $display("FAIL sequential: icount %0d pc %h want 4 04", icount, pc);
      end
   endtask

   task automatic test_stall();
      run_to(8'h05);
      stall = 1'b1;
      repeat (3) tick();
      checks++;
      if (pc !== 8'h05 || exec_w !== 1'b1) begin errors++; $display("FAIL stall_hold: pc %h exec %b want 05 1", pc, exec_w); end
      stall = 1'b0;
      tick();
      checks++;
      if (pc !== 8'h06 || state !== 2'b01) begin errors++; $display("FAIL stall_release: pc %h state %b want 06 01", pc, state); end
   endtask

   task automatic test_pc_load();
      rom[8'h0F] = 16'hC13F;
      run_to(8'h0F);
      tick();
      checks++;
      if (pc !== 8'h10) begin errors++; $display("FAIL no_load: pc %h want 10", pc); end
      goto(8'h0F);
      pc_load = 1'b1; tgt = 8'h13; tick(); pc_load = 1'b0; tgt = 8'h00;
      checks++;
      if (pc !== 8'h13) begin errors++; $display("FAIL pc_load: pc %h want 13", pc); end
   endtask

   task automatic test_cond_jump();
      rom[8'h14] = 16'hE008; rom[8'h15] = 16'hE001;
      rom[8'h21] = 16'hE002; rom[8'h22] = 16'hE004;
      r15 = 8'h20;
      run_to(8'h14); fe = 1'b1; tick(); fe = 1'b0;
      checks++;
      if (pc !== 8'h20) begin errors++; $display("FAIL jmp_e: pc %h want 20", pc); end
      goto(8'h14); tick();
      checks++;
      if (pc !== 8'h15) begin errors++; $display("FAIL jmp_e_not: pc %h want 15", pc); end
      run_to(8'h15); feq = 1'b1; tick(); feq = 1'b0;
      checks++;
      if (pc !== 8'h20) begin errors++; $display("FAIL jmp_eq: pc %h want 20", pc); end
      run_to(8'h21); feq = 1'b1; fe = 1'b0; ff = 1'b0; tick(); feq = 1'b0;
      checks++;
      if (pc !== 8'h22) begin errors++; $display("FAIL jmp_bit1: pc %h want 22", pc); end
      run_to(8'h22); ff = 1'b1; tick(); ff = 1'b0;
      checks++;
      if (pc !== 8'h20) begin errors++; $display("FAIL jmp_f: pc %h want 20", pc); end
   endtask

   task automatic test_wrap();
      rom[8'hFF] = 16'h1234;
      goto(8'hFF);
      tick();
      checks++;
      if (pc !== 8'h00) begin errors++; $display("FAIL wrap: pc %h want 00", pc); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 256; i++) begin
         rom[i] = 16'($urandom);
         if (rom[i][15:12] == 4'hF && rom[i][3:0] == 4'h0) rom[i][0] = 1'b1;
      end
      for (int i = 0; i < 800; i++) begin
         run     = ($urandom_range(0, 3) != 0);
         stall   = ($urandom_range(0, 3) == 0);
         pc_load = ($urandom_range(0, 9) == 0);
         tgt = 8'($urandom); r15 = 8'($urandom);
         fe = 1'($urandom); ff = 1'($urandom); feq = 1'($urandom);
         tick();
      end
      run = 1'b1; stall = 1'b0; pc_load = 1'b0; fe = 1'b0; ff = 1'b0; feq = 1'b0;
      fill_plain();
   endtask

   task automatic test_saturation();
      do_reset();
      run = 1'b1;
      repeat (2 * CMAX + 10) tick();
      checks++;
      if (icount !== {TB_CNT_W{1'b1}}) begin errors++; $display("FAIL saturate: icount %0d want %0d", icount, CMAX); end
   endtask

   task automatic test_halt();
      logic [7:0] hpc;
      do_reset();
      rom[8'h02] = 16'hF001; rom[8'h03] = 16'hF000;
      run = 1'b1;
      run_to(8'h03); tick();
      hpc = pc;
      checks++;
      if (halt_w !== 1'b1 || state !== 2'b11 || hpc !== 8'h03) begin
         errors++; $display("FAIL halt_enter: halt %b state %b pc %h want 1 11 03", halt_w, state, hpc);
      end
      for (int i = 0; i < 10; i++) begin
         run = 1'($urandom); stall = 1'($urandom); pc_load = 1'($urandom); tgt = 8'($urandom);
         tick();
      end
      stall = 1'b0; pc_load = 1'b0;
      checks++;
      if (pc !== 8'h03 || state !== 2'b11) begin errors++; $display("FAIL halt_stay: pc %h state %b want 03 11", pc, state); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      rom[8'h03] = 16'h2222;
      run = 1'b1;
      run_to(8'h02);
      stall = 1'b1; tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0; stall = 1'b0;
      checks++;
      if (state !== 2'b00 || pc !== 8'h00 || icount !== '0) begin
         errors++; $display("FAIL reset_stall: state %b pc %h icount %0d want 00 00 0", state, pc, icount);
      end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; stall = 1'b0; pc_load = 1'b0;
      feq = 1'b0; fe = 1'b0; ff = 1'b0; tgt = 8'h00; r15 = 8'h00;
      m_st = 0; m_pc = 8'h00; m_ir = 16'h0000; m_cnt = 0;
      fill_plain();
      test_reset();
      test_sequential();
      test_stall();
      test_pc_load();
      test_cond_jump();
      test_wrap();
      test_random();
      test_saturation();
      test_halt();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prog_fetch_ctrl.md
Name: prog_fetch_ctrl

Overview:
Instruction sequencer for the 16-bit CPU. It owns the 8-bit program counter, drives the asynchronous program ROM address, latches each instruction word and hands it to the datapath through a FETCH/EXEC handshake. It resolves the next PC from sequential increment, R15-write jumps (JUI/JUD), conditional jumps (opcode 4'hE) and halt (opcode 4'hF, sub-op 4'h0). It also keeps a saturating retired-instruction counter.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary
instr_i  in  16  ROM data for address pc_o, valid in the same cycle (combinational ROM)
stall_i  in  1  datapath/data-memory busy; holds EXEC
pc_load_i  in  1  datapath is writing R15 this EXEC cycle (LDI/MOV to R15)
pc_target_i  in  8  value being written to R15, low 8 bits
r15_i  in  8  current R15 contents, used as the conditional-jump target
flag_eq_i  in  1  datapath compare-equal flag
flag_e_i  in  1  datapath E flag
flag_f_i  in  1  datapath F flag
pc_o  out  8  program counter, drives ROM addr
ir_o  out  16  latched instruction
exec_o  out  1  1 while ir_o is being executed
halt_o  out  1  1 in HALT state
state_o  out  2  00 IDLE, 01 FETCH, 10 EXEC, 11 HALT
icount_o  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-EXEC or mid-stall):
  - state=IDLE, pc_o=RESET_PC, ir_o=16'h0000, icount_o=0.
  - exec_o=0, halt_o=0.
- Outputs: exec_o=(state==EXEC) and halt_o=(state==HALT), both decoded directly from state. pc_o, ir_o and icount_o are registers.
- IDLE:
  - run=1 -> FETCH. Otherwise stay.
  - pc_o holds its value, so execution resumes where it stopped.
- FETCH (exactly one cycle):
  - ir_o <= instr_i.
  - -> EXEC.
  - Fetch latency: instruction visible on ir_o one edge after pc_o is presented.
- EXEC:
  - stall_i=1: stay in EXEC; pc_o, ir_o and icount_o frozen; exec_o stays 1.
  - stall_i=0: instruction completes this edge.
  - icount_o increments unless it is already all-ones; it saturates there.
  - Next-PC priority, highest first:
    1. pc_load_i=1 -> pc_o <= pc_target_i.
    2. ir_o[15:12]==4'hE and cond -> pc_o <= r15_i. cond = (ir_o[3]&flag_e_i) | (ir_o[2]&flag_f_i) | (ir_o[0]&flag_eq_i). ir_o[1] is ignored.
    3. ir_o[15:12]==4'hF and ir_o[3:0]==4'h0 -> HALT. pc_o unchanged. icount_o still counts the HLT.
    4. Otherwise pc_o <= pc_o+1, modulo 256 (8'hFF wraps to 8'h00).
  - Next state: HALT if rule 3 fired; else FETCH if run=1; else IDLE.
- HALT: terminal; only rst leaves it. run, stall_i and pc_load_i are ignored there.
- Timing: an unstalled instruction takes 2 cycles (FETCH+EXEC). Each stalled cycle adds 1.
- Flags, pc_load_i, pc_target_i and r15_i are sampled only in the unstalled EXEC cycle.
- pc_load_i outside EXEC is ignored.
- Dropping run mid-EXEC does not abort: the instruction completes, then the block goes to IDLE.

Test Plan:
1. rst, then run=1, ROM at 00..03 = LDI words, no stalls -> pc_o 00,00,01,01,02,02,03; exec_o 0,1,0,1,...; icount_o=4 after 8 cycles of run.
2. stall_i=1 for 3 cycles during EXEC of pc=05 -> pc_o stays 05, exec_o=1 for 4 cycles, icount_o increments once, then pc_o=06.
3. EXEC of 16'hC13F at pc=0F with pc_load_i=1, pc_target_i=8'h13 -> next FETCH at pc_o=13; with pc_load_i=0 -> pc_o=10.
4. ir_o=16'hE008, r15_i=8'h20: flag_e_i=1 -> pc_o=20; flag_e_i=0 -> pc_o=pc+1. ir_o=16'hE001, flag_eq_i=1 -> pc_o=20.
5. pc_o=FF with a non-jump instruction -> pc_o=00. After 65535 completions, icount_o stays FFFF.
6. ir_o=16'hF000 -> halt_o=1, state_o=11, pc_o frozen, run toggling has no effect. rst asserted during a stalled EXEC -> next cycle state_o=00, pc_o=00, icount_o=0.
